// File: rtl/cursor_input_ctrl.sv
// cursor_input_ctrl
//   Front-end input stage for the minesweeper top level. Synchronises and
//   debounces five raw push-buttons, moves a cell cursor (with auto-repeat on
//   held direction buttons), drives the cursor's pixel top-left corner, and
//   turns a flip press into a request/acknowledge handshake that carries the
//   cell coordinates latched at the moment of the press.
//
// Ports
//   clock      system clock
//   reset      synchronous, active-high reset
//   right/left/up/down/flip  raw asynchronous push-buttons
//   flip_ack   processor has consumed the pending flip request
//   cell_col   cursor column
//   cell_row   cursor row
//   x_topleft  ORIGIN_X + cell_col*CELL_SIZE (registered, one cycle behind cell_col)
//   y_topleft  ORIGIN_Y + cell_row*CELL_SIZE (registered, one cycle behind cell_row)
//   flip_req   pending flip request
//   flip_col   column latched at the flip press
//   flip_row   row latched at the flip press
module cursor_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 40000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int GRID_COLS       = 16,
  parameter int GRID_ROWS       = 16,
  parameter int CELL_SIZE       = 25,
  parameter int ORIGIN_X        = 120,
  parameter int ORIGIN_Y        = 40
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       right,
  input  logic       left,
  input  logic       up,
  input  logic       down,
  input  logic       flip,
  input  logic       flip_ack,
  output logic [4:0] cell_col,
  output logic [4:0] cell_row,
  output logic [9:0] x_topleft,
  output logic [8:0] y_topleft,
  output logic       flip_req,
  output logic [4:0] flip_col,
  output logic [4:0] flip_row
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [4:0] COL_MAX = 5'(GRID_COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(GRID_ROWS - 1);

  // Button index map: 0 right, 1 left, 2 up, 3 down, 4 flip.
  logic [4:0] raw_btn;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [3:0] dir_move;

  assign raw_btn = {flip, down, up, left, right};

  typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} flip_state_t;
  flip_state_t state_reg;

  logic       flip_req_reg;
  logic [4:0] flip_col_reg;
  logic [4:0] flip_row_reg;
  logic [4:0] col_reg, col_next;
  logic [4:0] row_reg, row_next;
  logic [9:0] x_reg;
  logic [8:0] y_reg;

  genvar gi;

  // Synchroniser + debouncer per button. The counter only advances while the
  // synchronised level disagrees with the accepted level, so any agreement
  // (a glitch ending) restarts the stability window from zero.
  generate
    for (gi = 0; gi < 5; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic            level_prev_reg;
      logic [DB_W-1:0] db_cnt_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          sync1_reg      <= 1'b0;
          sync2_reg      <= 1'b0;
          level_reg      <= 1'b0;
          level_prev_reg <= 1'b0;
          db_cnt_reg     <= '0;
        end else begin
          sync1_reg      <= raw_btn[gi];
          sync2_reg      <= sync1_reg;
          level_prev_reg <= level_reg;
          if (sync2_reg == level_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            level_reg  <= sync2_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + DB_W'(1);
          end
        end
      end

      assign btn_level[gi] = level_reg;
      assign btn_press[gi] = level_reg & ~level_prev_reg;
    end
  endgenerate

  // Auto-repeat per direction. The counter is 1 on the cycle after the press,
  // so it equals the number of cycles since the press. The first repeat uses
  // REPEAT_DELAY; after that the phase bit switches the target to REPEAT_PERIOD
  // and the counter restarts at 1 on every repeat.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rpt
      logic [RPT_W-1:0] rpt_cnt_reg;
      logic             rpt_phase_reg;
      logic             rpt_fire;

      assign rpt_fire = btn_level[gi] & ~btn_press[gi] &
                        (rpt_phase_reg ? (rpt_cnt_reg == RPT_W'(REPEAT_PERIOD))
                                       : (rpt_cnt_reg == RPT_W'(REPEAT_DELAY)));

      always_ff @(posedge clock) begin
        if (reset) begin
          rpt_cnt_reg   <= '0;
          rpt_phase_reg <= 1'b0;
        end else if (btn_press[gi]) begin
          rpt_cnt_reg   <= RPT_W'(1);
          rpt_phase_reg <= 1'b0;
        end else if (btn_level[gi]) begin
          if (rpt_fire) begin
            rpt_cnt_reg   <= RPT_W'(1);
            rpt_phase_reg <= 1'b1;
          end else begin
            rpt_cnt_reg <= rpt_cnt_reg + RPT_W'(1);
          end
        end else begin
          rpt_cnt_reg   <= '0;
          rpt_phase_reg <= 1'b0;
        end
      end

      assign dir_move[gi] = btn_press[gi] | rpt_fire;
    end
  endgenerate

  // Moves are frozen while a request is pending, and a move coinciding with a
  // flip press is dropped so the latched coordinates are the pre-move ones.
  logic move_en;
  logic mv_right, mv_left, mv_up, mv_down;

  assign move_en  = ~flip_req_reg & ~((state_reg == IDLE) & btn_press[4]);
  assign mv_right = move_en & dir_move[0] & ~dir_move[1];
  assign mv_left  = move_en & dir_move[1] & ~dir_move[0];
  assign mv_up    = move_en & dir_move[2] & ~dir_move[3];
  assign mv_down  = move_en & dir_move[3] & ~dir_move[2];

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (mv_right && (col_reg != COL_MAX)) begin
      col_next = col_reg + 5'd1;
    end else if (mv_left && (col_reg != 5'd0)) begin
      col_next = col_reg - 5'd1;
    end
    if (mv_down && (row_reg != ROW_MAX)) begin
      row_next = row_reg + 5'd1;
    end else if (mv_up && (row_reg != 5'd0)) begin
      row_next = row_reg - 5'd1;
    end
  end

  // Pixel coordinates are computed from the registered cell position, hence
  // they trail cell_col/cell_row by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_reg <= 5'd0;
      row_reg <= 5'd0;
      x_reg   <= 10'(ORIGIN_X);
      y_reg   <= 9'(ORIGIN_Y);
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
      x_reg   <= 10'(ORIGIN_X) + 10'(col_reg) * 10'(CELL_SIZE);
      y_reg   <= 9'(ORIGIN_Y) + 9'(row_reg) * 9'(CELL_SIZE);
    end
  end

  // Flip handshake. An ack is only honoured in REQ, which guarantees
  // flip_req is high for at least one full cycle. WAIT_REL swallows a held
  // button so one press yields exactly one request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      flip_req_reg <= 1'b0;
      flip_col_reg <= 5'd0;
      flip_row_reg <= 5'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (btn_press[4]) begin
            flip_col_reg <= col_reg;
            flip_row_reg <= row_reg;
            flip_req_reg <= 1'b1;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          if (flip_ack) begin
            flip_req_reg <= 1'b0;
            state_reg    <= btn_level[4] ? WAIT_REL : IDLE;
          end
        end
        WAIT_REL: begin
          if (!btn_level[4]) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          flip_req_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign cell_col  = col_reg;
  assign cell_row  = row_reg;
  assign x_topleft = x_reg;
  assign y_topleft = y_reg;
  assign flip_req  = flip_req_reg;
  assign flip_col  = flip_col_reg;
  assign flip_row  = flip_row_reg;

endmodule

// File: tb/tb_cursor_input_ctrl.sv
// Testbench for cursor_input_ctrl with short debounce/repeat parameters.
// Table-driven cursor moves checked through a scoreboard queue, plus
// hand-written sequences for latency, auto-repeat, saturation, the flip
// handshake and reset during a pending request.
module tb_cursor_input_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       right = 1'b0;
  logic       left  = 1'b0;
  logic       up    = 1'b0;
  logic       down  = 1'b0;
  logic       flip  = 1'b0;
  logic       flip_ack = 1'b0;
  logic [4:0] cell_col;
  logic [4:0] cell_row;
  logic [9:0] x_topleft;
  logic [8:0] y_topleft;
  logic       flip_req;
  logic [4:0] flip_col;
  logic [4:0] flip_row;

  cursor_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .right    (right),
    .left     (left),
    .up       (up),
    .down     (down),
    .flip     (flip),
    .flip_ack (flip_ack),
    .cell_col (cell_col),
    .cell_row (cell_row),
    .x_topleft(x_topleft),
    .y_topleft(y_topleft),
    .flip_req (flip_req),
    .flip_col (flip_col),
    .flip_row (flip_row)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // dirs = {down, up, left, right}
  typedef struct {
    logic [3:0] dirs;
    int         hold;
    int         exp_col;
    int         exp_row;
  } vec_t;

  typedef struct {
    int col;
    int row;
  } exp_t;

  vec_t vecs[17];
  exp_t sb_q[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic press_dirs(input logic [3:0] d, input int hold, input int idle);
    {down, up, left, right} = d;
    tick(hold);
    {down, up, left, right} = 4'b0000;
    tick(idle);
  endtask

  task automatic wait_req(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick(1);
      if (flip_req) seen = 1'b1;
    end
  endtask

  initial begin
    int   prev;
    int   t0;
    int   moves;
    int   chg_idx;
    int   x_at;
    int   x_after;
    int   maxc;
    int   req_highs;
    bit   seen;
    exp_t e;
    int   offs[$];
    int   exp_offs[6];

    exp_offs = '{0, 20, 28, 36, 44, 52};

    vecs[0]  = '{4'b0001,  3, 0, 0};  // right glitch
    vecs[1]  = '{4'b1000,  3, 0, 0};  // down glitch
    vecs[2]  = '{4'b1000, 10, 0, 1};
    vecs[3]  = '{4'b1000, 10, 0, 2};
    vecs[4]  = '{4'b0001, 10, 1, 2};
    vecs[5]  = '{4'b0001, 10, 2, 2};
    vecs[6]  = '{4'b0001, 10, 3, 2};
    vecs[7]  = '{4'b1000, 10, 3, 3};
    vecs[8]  = '{4'b0110, 10, 2, 2};  // left+up diagonal
    vecs[9]  = '{4'b0011, 10, 2, 2};  // left+right cancel
    vecs[10] = '{4'b1100, 10, 2, 2};  // up+down cancel
    vecs[11] = '{4'b0100, 10, 2, 1};
    vecs[12] = '{4'b0100, 10, 2, 0};
    vecs[13] = '{4'b0100, 10, 2, 0};  // saturate at row 0
    vecs[14] = '{4'b0010, 10, 1, 0};
    vecs[15] = '{4'b0010, 10, 0, 0};
    vecs[16] = '{4'b0010, 10, 0, 0};  // saturate at col 0

    // Reset and idle
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    check("rst_col", cell_col, 0);
    check("rst_row", cell_row, 0);
    check("rst_x", x_topleft, 120);
    check("rst_y", y_topleft, 40);
    check("rst_req", flip_req, 0);
    check("rst_fcol", flip_col, 0);
    check("rst_frow", flip_row, 0);

    // Table-driven cursor moves through the scoreboard
    for (int v = 0; v < 17; v++) begin
      sb_q.push_back('{vecs[v].exp_col, vecs[v].exp_row});
      press_dirs(vecs[v].dirs, vecs[v].hold, 12);
      e = sb_q.pop_front();
      $display("vec %0d: dirs=%b hold=%0d -> col=%0d row=%0d x=%0d y=%0d",
               v, vecs[v].dirs, vecs[v].hold, cell_col, cell_row, x_topleft, y_topleft);
      check($sformatf("vec%0d_col", v), cell_col, e.col);
      check($sformatf("vec%0d_row", v), cell_row, e.row);
      check($sformatf("vec%0d_x", v), x_topleft, 120 + 25 * e.col);
      check($sformatf("vec%0d_y", v), y_topleft, 40 + 25 * e.row);
    end

    // Right held 10 cycles: exactly one move, x one cycle behind col
    prev = cell_col; moves = 0; chg_idx = -1; x_at = -1; x_after = -1;
    right = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) right = 1'b0;
      tick(1);
      if (chg_idx >= 0 && i == chg_idx + 1) x_after = x_topleft;
      if (int'(cell_col) != prev) begin
        moves++;
        if (chg_idx < 0) begin
          chg_idx = i;
          x_at = x_topleft;
        end
        prev = cell_col;
      end
    end
    right = 1'b0;
    $display("single right: moves=%0d col=%0d x_at=%0d x_after=%0d", moves, cell_col, x_at, x_after);
    check("single_moves", moves, 1);
    check("single_col", cell_col, 1);
    check("single_x_lag", x_at, 120);
    check("single_x", x_after, 145);
    tick(12);

    // Auto-repeat timing from (0,0)
    reset = 1'b1; tick(1); reset = 1'b0; tick(2);
    prev = cell_col; t0 = -1; offs.delete();
    right = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (t0 >= 0 && i == t0 + 50) right = 1'b0;
      tick(1);
      if (int'(cell_col) != prev) begin
        if (t0 < 0) t0 = i;
        offs.push_back(i - t0);
        prev = cell_col;
      end
    end
    right = 1'b0;
    tick(12);
    $display("repeat: moves=%0d col=%0d", offs.size(), cell_col);
    check("rpt_count", offs.size(), 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("rpt_off%0d", k), (k < offs.size()) ? offs[k] : -1, exp_offs[k]);
    check("rpt_col", cell_col, 6);

    // Long hold saturates at the right edge
    maxc = 0;
    right = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (int'(cell_col) > maxc) maxc = cell_col;
    end
    right = 1'b0;
    tick(12);
    $display("saturate: col=%0d x=%0d max=%0d", cell_col, x_topleft, maxc);
    check("sat_col", cell_col, 15);
    check("sat_x", x_topleft, 495);
    check("sat_max", maxc, 15);

    // Flip handshake at (5,7)
    reset = 1'b1; tick(1); reset = 1'b0; tick(2);
    for (int k = 0; k < 5; k++) press_dirs(4'b1001, 10, 12);
    for (int k = 0; k < 2; k++) press_dirs(4'b1000, 10, 12);
    check("pos57_col", cell_col, 5);
    check("pos57_row", cell_row, 7);
    flip = 1'b1;
    wait_req(20, seen);
    $display("flip press: req=%0d fcol=%0d frow=%0d", flip_req, flip_col, flip_row);
    check("flip_req_rise", seen, 1);
    check("flip_col", flip_col, 5);
    check("flip_row", flip_row, 7);
    press_dirs(4'b1000, 10, 12);
    $display("down during req: row=%0d req=%0d", cell_row, flip_req);
    check("req_move_row", cell_row, 7);
    check("req_hold", flip_req, 1);
    check("req_frow_stable", flip_row, 7);
    flip_ack = 1'b1;
    tick(1);
    flip_ack = 1'b0;
    check("ack_clear", flip_req, 0);
    req_highs = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (flip_req) req_highs++;
    end
    check("held_no_rereq", req_highs, 0);
    flip = 1'b0;
    tick(15);
    check("release_no_req", flip_req, 0);

    // New press after release, acknowledged after the button is released
    seen = 1'b0;
    flip = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) flip = 1'b0;
      tick(1);
      if (flip_req) seen = 1'b1;
    end
    tick(10);
    $display("second flip: seen=%0d req=%0d", seen, flip_req);
    check("flip2_seen", seen, 1);
    check("flip2_held", flip_req, 1);
    flip_ack = 1'b1;
    tick(1);
    flip_ack = 1'b0;
    tick(3);
    check("flip2_ack", flip_req, 0);

    // Move to (4,4), raise a request, then reset mid-handshake
    press_dirs(4'b0010, 10, 12);
    for (int k = 0; k < 3; k++) press_dirs(4'b0100, 10, 12);
    check("pos44_col", cell_col, 4);
    check("pos44_row", cell_row, 4);
    flip = 1'b1;
    wait_req(20, seen);
    check("flip3_seen", seen, 1);
    check("flip3_col", flip_col, 4);
    check("flip3_row", flip_row, 4);
    reset = 1'b1;
    tick(1);
    $display("reset mid-req: req=%0d col=%0d row=%0d", flip_req, cell_col, cell_row);
    check("rr_req", flip_req, 0);
    check("rr_col", cell_col, 0);
    check("rr_row", cell_row, 0);
    check("rr_fcol", flip_col, 0);
    check("rr_x", x_topleft, 120);
    reset = 1'b0;
    flip = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cursor_input_ctrl.md
Name: cursor_input_ctrl

Overview:
- Front-end input stage for the minesweeper top level.
- Synchronises and debounces the five raw push-buttons (right, left, up, down, flip).
- Moves a cell cursor over the board, with auto-repeat on held direction buttons, and drives the cursor's pixel top-left (x_topleft, y_topleft) consumed by the processor and VGA path.
- Converts a flip press into a held request/acknowledge handshake carrying the latched cell coordinates, so the processor never misses or double-counts a flip.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change (5 ms at 100 MHz).
- REPEAT_DELAY, 40000000: cycles a direction must be held after its press before auto-repeat starts.
- REPEAT_PERIOD, 10000000: cycles between auto-repeat moves.
- GRID_COLS, 16: board columns (max 32).
- GRID_ROWS, 16: board rows (max 32).
- CELL_SIZE, 25: cell edge in pixels.
- ORIGIN_X, 120: pixel x of cell (0,0).
- ORIGIN_Y, 40: pixel y of cell (0,0).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- right  in  1  raw button, asynchronous
- left  in  1  raw button, asynchronous
- up  in  1  raw button, asynchronous
- down  in  1  raw button, asynchronous
- flip  in  1  raw button, asynchronous
- flip_ack  in  1  processor has consumed the flip request
- cell_col  out  5  cursor column
- cell_row  out  5  cursor row
- x_topleft  out  10  ORIGIN_X + cell_col*CELL_SIZE
- y_topleft  out  9  ORIGIN_Y + cell_row*CELL_SIZE
- flip_req  out  1  pending flip request
- flip_col  out  5  column latched at flip press
- flip_row  out  5  row latched at flip press

Behaviour:
- Reset: synchronous; wins over all other activity, including mid-debounce or mid-handshake. After reset:
  - cell_col=0, cell_row=0, x_topleft=ORIGIN_X, y_topleft=ORIGIN_Y.
  - flip_req=0, flip_col=0, flip_row=0.
  - All synchroniser, debounce and repeat state cleared; debounced levels 0; FSM in IDLE.
- Synchroniser: 2-flop per button.
- Debounce, per button:
  - A counter runs while the synchronised level differs from the debounced level, and clears whenever they agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES has no effect.
- Press event: one-cycle pulse on a debounced 0->1 transition.
- Auto-repeat, per direction:
  - The repeat counter starts at the press event.
  - While the debounced level stays 1, an extra move event fires at REPEAT_DELAY cycles after the press, then every REPEAT_PERIOD cycles.
  - Release clears the counter.
- Cursor update: occurs on the clock edge after a move event.
  - Right: col+1, saturating at GRID_COLS-1. Left: col-1, saturating at 0. Up: row-1, saturating at 0. Down: row+1, saturating at GRID_ROWS-1. No wrap-around.
  - Left and right events in the same cycle cancel; up and down likewise.
  - A horizontal and a vertical event in the same cycle both apply (diagonal step).
  - Moves are ignored while flip_req=1; repeat counters keep running.
- Pixel outputs:
  - x_topleft and y_topleft are registered, one cycle after cell_col/cell_row.
  - Computed by constant multiply, no truncation for the default parameters.
- Flip FSM (IDLE, REQ, WAIT_REL):
  - IDLE: on a flip press event, latch flip_col=cell_col and flip_row=cell_row, set flip_req=1, go to REQ. If a move event occurs in the same cycle, the pre-move coordinates are latched and the move is dropped.
  - REQ: flip_req holds at 1 and flip_col/flip_row are stable until flip_ack=1. Then on the next edge flip_req=0, going to WAIT_REL if debounced flip=1, else IDLE. flip_ack may arrive the same cycle flip_req rises: it is honoured one cycle later (minimum request width 1 cycle).
  - WAIT_REL: go to IDLE when debounced flip=0. A held flip never generates a second request.
  - flip_ack outside REQ is ignored.

Test Plan:
Simulation parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset then idle 10 cycles -> cell_col=0, cell_row=0, x_topleft=120, y_topleft=40, flip_req=0.
- Right pulse of 3 cycles -> no move. Right held 10 cycles -> cell_col=1 and, one cycle later, x_topleft=145; exactly one move.
- Right held 60 cycles after debounce -> moves at press, +20, +28, +36, +44, +52, giving cell_col=6. Then hold at col 15 -> saturates at 15, x_topleft=495.
- Left and up asserted simultaneously from (3,3) -> (2,2). Left and right simultaneously -> column unchanged.
- Flip at (5,7) -> flip_req=1, flip_col=5, flip_row=7. Down press during REQ -> row stays 7. flip_ack pulse with flip still held -> flip_req=0 and no new request until release followed by a new press.
- Reset asserted while flip_req=1 with cursor at (4,4) -> next cycle flip_req=0 and cell position (0,0).
